// File: rtl/filter_pool_ctrl.sv
// Sequencer for the 16-filter weight pool: loads N filters of S bytes, then replays S weight reads per window for W windows.
// Latency: 1 cycle from config to ready; 1 cycle from win_ack_o to first read enable. Backpressure: data_valid_i/stall_i hold all counters.
module filter_pool_ctrl #(
  parameter int INPUT_BIT_WIDTH          = 8,
  parameter int NUM_OF_FILTERS_BIT_WIDTH = 4,
  parameter int NUM_OF_MAC_UNIT          = 16,
  parameter int ITER_BIT_WIDTH           = 6,
  parameter int REG_POOL_BIT_WIDTH       = 6,
  parameter int BYTES_OF_REG             = 36,
  parameter int WIN_CNT_BIT_WIDTH        = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_valid_i,
  input  logic [NUM_OF_FILTERS_BIT_WIDTH:0]   cfg_num_filters_i,
  input  logic [REG_POOL_BIT_WIDTH-1:0]       cfg_filter_size_i,
  input  logic [WIN_CNT_BIT_WIDTH-1:0]        cfg_num_windows_i,
  output logic                                cfg_err_o,
  input  logic                                data_valid_i,
  output logic                                data_ready_o,
  output logic                                filter_fetch_en_o,
  output logic [NUM_OF_FILTERS_BIT_WIDTH-1:0] filter_sel_o,
  output logic [REG_POOL_BIT_WIDTH-1:0]       byte_counter_filter_fetch_o,
  input  logic                                win_valid_i,
  output logic                                win_ack_o,
  input  logic                                stall_i,
  output logic [NUM_OF_MAC_UNIT-1:0]          mac_unit_en_o,
  output logic [ITER_BIT_WIDTH-1:0]           iteration_o,
  output logic                                first_iter_o,
  output logic                                last_iter_o,
  output logic                                busy_o,
  output logic                                done_o
);

  localparam int NFW = NUM_OF_FILTERS_BIT_WIDTH + 1;
  localparam logic [NFW-1:0]                MAX_FILTERS = NFW'(NUM_OF_MAC_UNIT);
  localparam logic [REG_POOL_BIT_WIDTH-1:0] MAX_BYTES   = REG_POOL_BIT_WIDTH'(BYTES_OF_REG);

  // Counter widths must be able to address every filter, byte and iteration.
  if (INPUT_BIT_WIDTH < 1 || NUM_OF_MAC_UNIT > (1 << NUM_OF_FILTERS_BIT_WIDTH) ||
      BYTES_OF_REG >= (1 << REG_POOL_BIT_WIDTH) || BYTES_OF_REG > (1 << ITER_BIT_WIDTH)) begin : g_param_check
    $error("filter_pool_ctrl: inconsistent parameter widths");
  end

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_WIN, COMPUTE, DONE} state_t;

  state_t                                state_q, state_d;
  logic [NFW-1:0]                        num_filters_q, num_filters_d;
  logic [REG_POOL_BIT_WIDTH-1:0]         filter_size_q, filter_size_d;
  logic [WIN_CNT_BIT_WIDTH-1:0]          num_windows_q, num_windows_d;
  logic [NUM_OF_FILTERS_BIT_WIDTH-1:0]   sel_q, sel_d;
  logic [REG_POOL_BIT_WIDTH-1:0]         byte_q, byte_d;
  logic [ITER_BIT_WIDTH-1:0]             iter_q, iter_d;
  logic [WIN_CNT_BIT_WIDTH-1:0]          win_cnt_q, win_cnt_d;

  logic                                  cfg_ok;
  logic                                  last_byte;
  logic                                  last_filter;
  logic                                  last_iter;
  logic [WIN_CNT_BIT_WIDTH-1:0]          win_cnt_inc;
  logic [NUM_OF_MAC_UNIT-1:0]            filter_mask;

  assign cfg_ok = (cfg_num_filters_i != '0) && (cfg_num_filters_i <= MAX_FILTERS) &&
                  (cfg_filter_size_i != '0) && (cfg_filter_size_i <= MAX_BYTES) &&
                  (cfg_num_windows_i != '0);

  assign last_byte   = (byte_q == filter_size_q - REG_POOL_BIT_WIDTH'(1));
  assign last_filter = ({1'b0, sel_q} == num_filters_q - NFW'(1));
  assign last_iter   = (iter_q == ITER_BIT_WIDTH'(filter_size_q - REG_POOL_BIT_WIDTH'(1)));
  assign win_cnt_inc = win_cnt_q + WIN_CNT_BIT_WIDTH'(1);

  always_comb begin
    filter_mask = '0;
    for (int i = 0; i < NUM_OF_MAC_UNIT; i++) begin
      filter_mask[i] = (i < 32'(num_filters_q));
    end
  end

  always_comb begin
    state_d       = state_q;
    num_filters_d = num_filters_q;
    filter_size_d = filter_size_q;
    num_windows_d = num_windows_q;
    sel_d         = sel_q;
    byte_d        = byte_q;
    iter_d        = iter_q;
    win_cnt_d     = win_cnt_q;

    cfg_err_o         = 1'b0;
    data_ready_o      = 1'b0;
    filter_fetch_en_o = 1'b0;
    win_ack_o         = 1'b0;
    mac_unit_en_o     = '0;
    first_iter_o      = 1'b0;
    last_iter_o       = 1'b0;
    done_o            = 1'b0;
    busy_o            = (state_q != IDLE);
    filter_sel_o                = sel_q;
    byte_counter_filter_fetch_o = byte_q;
    iteration_o                 = iter_q;

    case (state_q)
      IDLE: begin
        if (cfg_valid_i) begin
          if (cfg_ok) begin
            num_filters_d = cfg_num_filters_i;
            filter_size_d = cfg_filter_size_i;
            num_windows_d = cfg_num_windows_i;
            sel_d         = '0;
            byte_d        = '0;
            iter_d        = '0;
            win_cnt_d     = '0;
            state_d       = LOAD;
          end else begin
            cfg_err_o = 1'b1;
          end
        end
      end
      LOAD: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          filter_fetch_en_o = 1'b1;
          if (last_byte) begin
            byte_d = '0;
            if (last_filter) begin
              sel_d   = '0;
              state_d = WAIT_WIN;
            end else begin
              sel_d = sel_q + NUM_OF_FILTERS_BIT_WIDTH'(1);
            end
          end else begin
            byte_d = byte_q + REG_POOL_BIT_WIDTH'(1);
          end
        end
      end
      WAIT_WIN: begin
        if (win_valid_i) begin
          win_ack_o = 1'b1;
          iter_d    = '0;
          state_d   = COMPUTE;
        end
      end
      COMPUTE: begin
        // Flags follow iter_q, so they naturally hold through a stall.
        first_iter_o = (iter_q == '0);
        last_iter_o  = last_iter;
        if (!stall_i) begin
          mac_unit_en_o = filter_mask;
          if (last_iter) begin
            iter_d    = '0;
            win_cnt_d = win_cnt_inc;
            state_d   = (win_cnt_inc == num_windows_q) ? DONE : WAIT_WIN;
          end else begin
            iter_d = iter_q + ITER_BIT_WIDTH'(1);
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      num_filters_q <= '0;
      filter_size_q <= '0;
      num_windows_q <= '0;
      sel_q         <= '0;
      byte_q        <= '0;
      iter_q        <= '0;
      win_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      num_filters_q <= num_filters_d;
      filter_size_q <= filter_size_d;
      num_windows_q <= num_windows_d;
      sel_q         <= sel_d;
      byte_q        <= byte_d;
      iter_q        <= iter_d;
      win_cnt_q     <= win_cnt_d;
    end
  end

endmodule

// File: tb/tb_filter_pool_ctrl.sv
// Randomized bench for filter_pool_ctrl against a count-based model of load order and window replay.
module tb_filter_pool_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid_i;
  logic [4:0]  cfg_num_filters_i;
  logic [5:0]  cfg_filter_size_i;
  logic [15:0] cfg_num_windows_i;
  logic        cfg_err_o;
  logic        data_valid_i;
  logic        data_ready_o;
  logic        filter_fetch_en_o;
  logic [3:0]  filter_sel_o;
  logic [5:0]  byte_counter_filter_fetch_o;
  logic        win_valid_i;
  logic        win_ack_o;
  logic        stall_i;
  logic [15:0] mac_unit_en_o;
  logic [5:0]  iteration_o;
  logic        first_iter_o;
  logic        last_iter_o;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_errs   = 0;

  filter_pool_ctrl dut (
    .clk                         (clk),
    .rst                         (rst),
    .cfg_valid_i                 (cfg_valid_i),
    .cfg_num_filters_i           (cfg_num_filters_i),
    .cfg_filter_size_i           (cfg_filter_size_i),
    .cfg_num_windows_i           (cfg_num_windows_i),
    .cfg_err_o                   (cfg_err_o),
    .data_valid_i                (data_valid_i),
    .data_ready_o                (data_ready_o),
    .filter_fetch_en_o           (filter_fetch_en_o),
    .filter_sel_o                (filter_sel_o),
    .byte_counter_filter_fetch_o (byte_counter_filter_fetch_o),
    .win_valid_i                 (win_valid_i),
    .win_ack_o                   (win_ack_o),
    .stall_i                     (stall_i),
    .mac_unit_en_o               (mac_unit_en_o),
    .iteration_o                 (iteration_o),
    .first_iter_o                (first_iter_o),
    .last_iter_o                 (last_iter_o),
    .busy_o                      (busy_o),
    .done_o                      (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    cfg_valid_i       = 1'b0;
    cfg_num_filters_i = '0;
    cfg_filter_size_i = '0;
    cfg_num_windows_i = '0;
    data_valid_i      = 1'b0;
    win_valid_i       = 1'b0;
    stall_i           = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(busy_o), 32'(0));
    chk({tag, "_ready"}, 32'(data_ready_o), 32'(0));
    chk({tag, "_fetch"}, 32'(filter_fetch_en_o), 32'(0));
    chk({tag, "_sel"},   32'(filter_sel_o), 32'(0));
    chk({tag, "_addr"},  32'(byte_counter_filter_fetch_o), 32'(0));
    chk({tag, "_ack"},   32'(win_ack_o), 32'(0));
    chk({tag, "_en"},    32'(mac_unit_en_o), 32'(0));
    chk({tag, "_iter"},  32'(iteration_o), 32'(0));
    chk({tag, "_first"}, 32'(first_iter_o), 32'(0));
    chk({tag, "_last"},  32'(last_iter_o), 32'(0));
    chk({tag, "_done"},  32'(done_o), 32'(0));
    chk({tag, "_err"},   32'(cfg_err_o), 32'(0));
  endtask

  // Model: byte k of the load goes to filter k/S, address k%S; each window is S unstalled reads.
  task automatic run_layer(input int n, input int s, input int w, input int dv_pct, input int wv_pct,
                           input int stall_pct, input bit dv_toggle, input bit stall_iter2);
    int          total = n * s;
    int          loaded = 0;
    int          win_done = 0;
    int          iter = 0;
    int          cyc = 0;
    int          stall_run = 0;
    int          acks = 0;
    int          dones = 0;
    bit          in_win = 1'b0;
    bit          finished = 1'b0;
    bit          loading;
    bit          exp_ack;
    bit          exp_done;
    logic [31:0] mask = (32'h1 << n) - 32'h1;

    @(posedge clk); #1;
    cfg_valid_i       = 1'b1;
    cfg_num_filters_i = 5'(n);
    cfg_filter_size_i = 6'(s);
    cfg_num_windows_i = 16'(w);
    @(negedge clk);
    chk("cfg_err_valid", 32'(cfg_err_o), 32'(0));
    chk("cfg_busy_pre",  32'(busy_o), 32'(0));
    chk("cfg_ready_pre", 32'(data_ready_o), 32'(0));
    @(posedge clk); #1;

    while (cyc < 20000) begin
      // Stray configs while busy must be ignored.
      cfg_valid_i       = !finished && ($urandom_range(7) == 0);
      cfg_num_filters_i = 5'($urandom_range(1, 16));
      cfg_filter_size_i = 6'($urandom_range(1, 36));
      cfg_num_windows_i = 16'($urandom_range(1, 5));
      data_valid_i = dv_toggle ? (cyc % 2 == 0) : ($urandom_range(99) < dv_pct);
      win_valid_i  = ($urandom_range(99) < wv_pct);
      if (stall_iter2) stall_i = in_win && (iter == 2) && (stall_run < 2);
      else             stall_i = ($urandom_range(99) < stall_pct);

      @(negedge clk);
      loading  = (loaded < total);
      exp_ack  = !loading && !in_win && (win_done < w) && win_valid_i;
      exp_done = !loading && !in_win && (win_done == w) && !finished;

      chk("busy",  32'(busy_o), 32'(!finished));
      chk("ready", 32'(data_ready_o), 32'(loading));
      chk("fetch", 32'(filter_fetch_en_o), 32'(loading && data_valid_i));
      if (loading && data_valid_i) begin
        chk("sel",  32'(filter_sel_o), loaded / s);
        chk("addr", 32'(byte_counter_filter_fetch_o), loaded % s);
      end
      chk("ack",  32'(win_ack_o), 32'(exp_ack));
      chk("en",   32'(mac_unit_en_o), (in_win && !stall_i) ? mask : 32'h0);
      if (in_win) begin
        chk("iter",  32'(iteration_o), iter);
        chk("first", 32'(first_iter_o), 32'(iter == 0));
        chk("last",  32'(last_iter_o), 32'(iter == s - 1));
      end else begin
        chk("first_idle", 32'(first_iter_o), 32'(0));
        chk("last_idle",  32'(last_iter_o), 32'(0));
      end
      chk("done",    32'(done_o), 32'(exp_done));
      chk("cfg_err", 32'(cfg_err_o), 32'(0));
      if (win_ack_o) acks++;
      if (done_o) dones++;

      if (finished) break;
      if (loading && data_valid_i) begin
        loaded++;
      end else if (exp_ack) begin
        in_win = 1'b1;
        iter   = 0;
      end else if (in_win && stall_i) begin
        stall_run++;
      end else if (in_win) begin
        if (iter == s - 1) begin
          in_win = 1'b0;
          win_done++;
        end else begin
          iter++;
        end
      end
      if (exp_done) finished = 1'b1;
      cyc++;
      @(posedge clk); #1;
    end
    chk("layer_end", 32'(finished), 32'(1));
    chk("ack_count", acks, w);
    chk("done_count", dones, 1);
    idle_inputs();
  endtask

  task automatic cfg_bad(input string tag, input int n, input int s, input int w);
    @(posedge clk); #1;
    cfg_valid_i       = 1'b1;
    cfg_num_filters_i = 5'(n);
    cfg_filter_size_i = 6'(s);
    cfg_num_windows_i = 16'(w);
    data_valid_i      = 1'b1;
    @(negedge clk);
    chk({tag, "_err"},   32'(cfg_err_o), 32'(1));
    chk({tag, "_busy"},  32'(busy_o), 32'(0));
    chk({tag, "_fetch"}, 32'(filter_fetch_en_o), 32'(0));
    @(posedge clk); #1;
    cfg_valid_i = 1'b0;
    @(negedge clk);
    chk({tag, "_err_gone"}, 32'(cfg_err_o), 32'(0));
    chk({tag, "_busy2"},    32'(busy_o), 32'(0));
    chk({tag, "_fetch2"},   32'(filter_fetch_en_o), 32'(0));
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    run_layer(2, 9, 1, 100, 100, 0, 1'b0, 1'b0);
    run_layer(2, 9, 1, 0, 100, 0, 1'b1, 1'b0);
    run_layer(16, 4, 3, 100, 100, 0, 1'b0, 1'b0);
    run_layer(3, 4, 1, 100, 100, 0, 1'b0, 1'b1);
    run_layer(1, 1, 3, 100, 100, 0, 1'b0, 1'b0);
    run_layer(16, 36, 2, 70, 60, 20, 1'b0, 1'b0);

    cfg_bad("n0", 0, 4, 1);
    cfg_bad("n17", 17, 4, 1);
    cfg_bad("s0", 2, 0, 1);
    cfg_bad("s37", 2, 37, 1);
    cfg_bad("w0", 2, 4, 0);

    // Reset in the middle of a load, with valid data and a config pending.
    @(posedge clk); #1;
    cfg_valid_i       = 1'b1;
    cfg_num_filters_i = 5'd2;
    cfg_filter_size_i = 6'd9;
    cfg_num_windows_i = 16'd1;
    @(posedge clk); #1;
    cfg_valid_i  = 1'b0;
    data_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_fetch", 32'(filter_fetch_en_o), 32'(1));
      chk("mid_addr",  32'(byte_counter_filter_fetch_o), i);
      @(posedge clk); #1;
    end
    rst         = 1'b1;
    cfg_valid_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    run_layer(2, 9, 1, 100, 100, 0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      run_layer($urandom_range(1, 16), $urandom_range(1, 36), $urandom_range(1, 3),
                $urandom_range(40, 100), $urandom_range(30, 100), $urandom_range(0, 40),
                1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
